// File: rtl/adbg_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adbg_tap_ctrl
// Purpose  : IEEE 1149.1 TAP controller for the advanced debug interface.
//            Decodes TMS into the 16-state TAP FSM, holds the instruction
//            register, generates the DR strobes and DEBUG select used by the
//            AXI debug top, and multiplexes TDO between IR, BYPASS, IDCODE
//            and the debug module's serial output.
//
// Build option:
//   JTAG_IDCODE_EN  defined   -> 32-bit IDCODE register present; reset/TLR
//                                load IR_IDCODE.
//                   undefined -> no IDCODE register; IR_IDCODE decodes as
//                                BYPASS; reset/TLR load IR_BYPASS.
//
// Ports:
//   tck_i              in   JTAG clock (posedge logic, negedge TDO)
//   trstn_i            in   asynchronous active-low reset
//   tms_i              in   test mode select
//   tdi_i              in   serial data in
//   tdo_o              out  serial data out (negedge registered)
//   tdo_oe_o           out  TDO output enable (negedge registered)
//   debug_tdo_i        in   serial output of the debug module
//   debug_select_o     out  IR holds the DEBUG opcode
//   shift_dr_o         out  FSM in Shift-DR
//   pause_dr_o         out  FSM in Pause-DR
//   update_dr_o        out  FSM in Update-DR
//   capture_dr_o       out  FSM in Capture-DR
//   test_logic_reset_o out  FSM in Test-Logic-Reset
//
// Revision : 1.0 - initial release
// ============================================================================
module adbg_tap_ctrl #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE    = 4'b0010,
  parameter logic [IR_WIDTH-1:0] IR_DEBUG     = 4'b1000,
  parameter logic [IR_WIDTH-1:0] IR_BYPASS    = 4'b1111
) (
  input  logic tck_i,
  input  logic trstn_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  input  logic debug_tdo_i,
  output logic debug_select_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic capture_dr_o,
  output logic test_logic_reset_o
);

`ifdef JTAG_IDCODE_EN
  localparam bit c_IDCODE_PRESENT = 1'b1;
`else
  localparam bit c_IDCODE_PRESENT = 1'b0;
`endif

  // Instruction loaded by reset and held while in Test-Logic-Reset.
  localparam logic [IR_WIDTH-1:0] c_IR_RESET   = c_IDCODE_PRESENT ? IR_IDCODE : IR_BYPASS;
  // Capture-IR pattern: LSBs 2'b01, upper bits zero.
  localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = IR_WIDTH'(2'b01);

  typedef enum logic [3:0] {
    S_TLR      = 4'h0,
    S_RTI      = 4'h1,
    S_SEL_DR   = 4'h2,
    S_CAP_DR   = 4'h3,
    S_SHIFT_DR = 4'h4,
    S_EX1_DR   = 4'h5,
    S_PAUSE_DR = 4'h6,
    S_EX2_DR   = 4'h7,
    S_UPD_DR   = 4'h8,
    S_SEL_IR   = 4'h9,
    S_CAP_IR   = 4'hA,
    S_SHIFT_IR = 4'hB,
    S_EX1_IR   = 4'hC,
    S_PAUSE_IR = 4'hD,
    S_EX2_IR   = 4'hE,
    S_UPD_IR   = 4'hF
  } tap_state_t;

  tap_state_t          r_state;
  tap_state_t          w_state_next;
  logic                r_tlr;
  logic                r_shift_dr;
  logic                r_pause_dr;
  logic                r_update_dr;
  logic                r_capture_dr;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] r_ir;
  logic                r_debug_sel;
  logic                r_bypass;
  logic                w_sel_idcode;
  logic                w_idcode_lsb;
  logic                w_tdo;
  logic                r_tdo;
  logic                r_tdo_oe;

  // --------------------------------------------------------------------------
  // TAP next-state decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_TLR:      w_state_next = tms_i ? S_TLR    : S_RTI;
      S_RTI:      w_state_next = tms_i ? S_SEL_DR : S_RTI;
      S_SEL_DR:   w_state_next = tms_i ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR:   w_state_next = tms_i ? S_EX1_DR : S_SHIFT_DR;
      S_SHIFT_DR: w_state_next = tms_i ? S_EX1_DR : S_SHIFT_DR;
      S_EX1_DR:   w_state_next = tms_i ? S_UPD_DR : S_PAUSE_DR;
      S_PAUSE_DR: w_state_next = tms_i ? S_EX2_DR : S_PAUSE_DR;
      S_EX2_DR:   w_state_next = tms_i ? S_UPD_DR : S_SHIFT_DR;
      S_UPD_DR:   w_state_next = tms_i ? S_SEL_DR : S_RTI;
      S_SEL_IR:   w_state_next = tms_i ? S_TLR    : S_CAP_IR;
      S_CAP_IR:   w_state_next = tms_i ? S_EX1_IR : S_SHIFT_IR;
      S_SHIFT_IR: w_state_next = tms_i ? S_EX1_IR : S_SHIFT_IR;
      S_EX1_IR:   w_state_next = tms_i ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: w_state_next = tms_i ? S_EX2_IR : S_PAUSE_IR;
      S_EX2_IR:   w_state_next = tms_i ? S_UPD_IR : S_SHIFT_IR;
      S_UPD_IR:   w_state_next = tms_i ? S_SEL_DR : S_RTI;
      default:    w_state_next = S_TLR;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and strobes. Strobes are registered from the next state so
  // each one is a clean flop output that is high for exactly the tck period
  // the FSM spends in the matching state.
  // --------------------------------------------------------------------------
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_state      <= S_TLR;
      r_tlr        <= 1'b1;
      r_shift_dr   <= 1'b0;
      r_pause_dr   <= 1'b0;
      r_update_dr  <= 1'b0;
      r_capture_dr <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_tlr        <= (w_state_next == S_TLR);
      r_shift_dr   <= (w_state_next == S_SHIFT_DR);
      r_pause_dr   <= (w_state_next == S_PAUSE_DR);
      r_update_dr  <= (w_state_next == S_UPD_DR);
      r_capture_dr <= (w_state_next == S_CAP_DR);
    end
  end

  // --------------------------------------------------------------------------
  // Instruction register. The reset opcode is forced on the same edge that
  // enters Test-Logic-Reset so the IR and debug select are already settled
  // while test_logic_reset_o is high. Any partial shift is dropped there.
  // --------------------------------------------------------------------------
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_ir_shift  <= '0;
      r_ir        <= c_IR_RESET;
      r_debug_sel <= (c_IR_RESET == IR_DEBUG);
    end else if (w_state_next == S_TLR) begin
      r_ir_shift  <= '0;
      r_ir        <= c_IR_RESET;
      r_debug_sel <= (c_IR_RESET == IR_DEBUG);
    end else begin
      case (r_state)
        S_CAP_IR:   r_ir_shift <= c_IR_CAPTURE;
        S_SHIFT_IR: r_ir_shift <= {tdi_i, r_ir_shift[IR_WIDTH-1:1]};
        S_UPD_IR: begin
          r_ir        <= r_ir_shift;
          r_debug_sel <= (r_ir_shift == IR_DEBUG);
        end
        default: ;
      endcase
    end
  end

  // Opcodes other than DEBUG and (when present) IDCODE fall through to BYPASS.
  assign w_sel_idcode = c_IDCODE_PRESENT && (r_ir == IR_IDCODE);

  // --------------------------------------------------------------------------
  // BYPASS register
  // --------------------------------------------------------------------------
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_bypass <= 1'b0;
    end else begin
      case (r_state)
        S_CAP_DR:   r_bypass <= 1'b0;
        S_SHIFT_DR: r_bypass <= tdi_i;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // IDCODE register
  // --------------------------------------------------------------------------
`ifdef JTAG_IDCODE_EN
  logic [31:0] r_idcode_shift;

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_idcode_shift <= IDCODE_VALUE;
    end else begin
      case (r_state)
        S_CAP_DR:   r_idcode_shift <= IDCODE_VALUE;
        S_SHIFT_DR: r_idcode_shift <= {tdi_i, r_idcode_shift[31:1]};
        default: ;
      endcase
    end
  end

  assign w_idcode_lsb = r_idcode_shift[0];
`else
  // Never selected in this build (w_sel_idcode is constant 0).
  assign w_idcode_lsb = IDCODE_VALUE[0];
`endif

  // --------------------------------------------------------------------------
  // TDO source select, launched on the falling edge so TDO is stable across
  // the next rising edge at the far end of the scan chain.
  // --------------------------------------------------------------------------
  always_comb begin
    w_tdo = 1'b0;
    if (r_state == S_SHIFT_IR) begin
      w_tdo = r_ir_shift[0];
    end else if (r_state == S_SHIFT_DR) begin
      if (r_debug_sel) begin
        w_tdo = debug_tdo_i;
      end else if (w_sel_idcode) begin
        w_tdo = w_idcode_lsb;
      end else begin
        w_tdo = r_bypass;
      end
    end
  end

  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else begin
      r_tdo    <= w_tdo;
      r_tdo_oe <= (r_state == S_SHIFT_IR) || (r_state == S_SHIFT_DR);
    end
  end

  assign tdo_o              = r_tdo;
  assign tdo_oe_o           = r_tdo_oe;
  assign debug_select_o     = r_debug_sel;
  assign shift_dr_o         = r_shift_dr;
  assign pause_dr_o         = r_pause_dr;
  assign update_dr_o        = r_update_dr;
  assign capture_dr_o       = r_capture_dr;
  assign test_logic_reset_o = r_tlr;

endmodule
`default_nettype wire

// File: tb/tb_adbg_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adbg_tap_ctrl
// Purpose  : Self-checking bench for adbg_tap_ctrl. A reference model keeps
//            the TAP state as a named state looked up in a transition table
//            and the scan registers as bit queues (LSB at the front). Every
//            tck step compares all DUT outputs against the model, and the
//            directed scenarios also compare collected TDO words against
//            fixed expected values. Follows JTAG_IDCODE_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adbg_tap_ctrl;

  localparam logic [31:0] IDCODE_VALUE = 32'h149511C3;
  localparam logic [3:0]  IR_IDCODE    = 4'b0010;
  localparam logic [3:0]  IR_DEBUG     = 4'b1000;
  localparam logic [3:0]  IR_BYPASS    = 4'b1111;
`ifdef JTAG_IDCODE_EN
  localparam bit          IDCODE_EN    = 1'b1;
`else
  localparam bit          IDCODE_EN    = 1'b0;
`endif
  localparam logic [3:0]  IR_RESET     = IDCODE_EN ? IR_IDCODE : IR_BYPASS;

  logic tck_i = 1'b0;
  logic trstn_i;
  logic tms_i;
  logic tdi_i;
  logic debug_tdo_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic debug_select_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic capture_dr_o;
  logic test_logic_reset_o;

  int checks   = 0;
  int failures = 0;

  adbg_tap_ctrl dut (
    .tck_i              (tck_i),
    .trstn_i            (trstn_i),
    .tms_i              (tms_i),
    .tdi_i              (tdi_i),
    .tdo_o              (tdo_o),
    .tdo_oe_o           (tdo_oe_o),
    .debug_tdo_i        (debug_tdo_i),
    .debug_select_o     (debug_select_o),
    .shift_dr_o         (shift_dr_o),
    .pause_dr_o         (pause_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_dr_o       (capture_dr_o),
    .test_logic_reset_o (test_logic_reset_o)
  );

  always #10 tck_i = ~tck_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  string      nxt0 [string];
  string      nxt1 [string];
  string      m_state;
  logic [3:0] m_ir;
  bit         ir_q [$];
  bit         dr_q [$];

  function automatic void build_table();
    string sides [2];
    sides[0] = "DR";
    sides[1] = "IR";
    nxt0["TLR"] = "RTI";    nxt1["TLR"] = "TLR";
    nxt0["RTI"] = "RTI";    nxt1["RTI"] = "SEL-DR";
    for (int k = 0; k < 2; k++) begin
      string s;
      s = sides[k];
      nxt0[{"SEL-", s}]   = {"CAP-", s};
      nxt1[{"SEL-", s}]   = (s == "DR") ? "SEL-IR" : "TLR";
      nxt0[{"CAP-", s}]   = {"SHIFT-", s};
      nxt1[{"CAP-", s}]   = {"EX1-", s};
      nxt0[{"SHIFT-", s}] = {"SHIFT-", s};
      nxt1[{"SHIFT-", s}] = {"EX1-", s};
      nxt0[{"EX1-", s}]   = {"PAUSE-", s};
      nxt1[{"EX1-", s}]   = {"UPD-", s};
      nxt0[{"PAUSE-", s}] = {"PAUSE-", s};
      nxt1[{"PAUSE-", s}] = {"EX2-", s};
      nxt0[{"EX2-", s}]   = {"SHIFT-", s};
      nxt1[{"EX2-", s}]   = {"UPD-", s};
      nxt0[{"UPD-", s}]   = "RTI";
      nxt1[{"UPD-", s}]   = "SEL-DR";
    end
  endfunction

  function automatic void model_reset();
    m_state = "TLR";
    m_ir    = IR_RESET;
    ir_q.delete();
    dr_q.delete();
  endfunction

  function automatic bit model_idcode_sel();
    return IDCODE_EN && (m_ir == IR_IDCODE);
  endfunction

  // Actions of the state being left, then the transition.
  function automatic void model_clock(bit tms, bit tdi);
    logic [31:0] idv;
    string cur;
    cur = m_state;
    if (cur == "CAP-IR") begin
      ir_q.delete();
      ir_q.push_back(1'b1);
      for (int i = 1; i < 4; i++) ir_q.push_back(1'b0);
    end
    if (cur == "SHIFT-IR" && ir_q.size() > 0) begin
      void'(ir_q.pop_front());
      ir_q.push_back(tdi);
    end
    if (cur == "UPD-IR") begin
      for (int i = 0; i < 4; i++) m_ir[i] = ir_q[i];
    end
    if (cur == "CAP-DR") begin
      dr_q.delete();
      if (m_ir != IR_DEBUG) begin
        if (model_idcode_sel()) begin
          idv = IDCODE_VALUE;
          for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
        end else begin
          dr_q.push_back(1'b0);
        end
      end
    end
    if (cur == "SHIFT-DR" && dr_q.size() > 0) begin
      void'(dr_q.pop_front());
      dr_q.push_back(tdi);
    end
    m_state = tms ? nxt1[cur] : nxt0[cur];
    if (m_state == "TLR") m_ir = IR_RESET;
  endfunction

  function automatic logic model_tdo(logic dbg);
    if (m_state == "SHIFT-IR") return (ir_q.size() > 0) ? ir_q[0] : 1'b0;
    if (m_state == "SHIFT-DR") begin
      if (m_ir == IR_DEBUG) return dbg;
      return (dr_q.size() > 0) ? dr_q[0] : 1'b0;
    end
    return 1'b0;
  endfunction

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic dbg);
    bit in_shift;
    in_shift = (m_state == "SHIFT-IR") || (m_state == "SHIFT-DR");
    chk({"tdo@", m_state},     {31'b0, tdo_o},              {31'b0, model_tdo(dbg)});
    chk({"tdo_oe@", m_state},  {31'b0, tdo_oe_o},           {31'b0, in_shift});
    chk({"tlr@", m_state},     {31'b0, test_logic_reset_o}, {31'b0, m_state == "TLR"});
    chk({"shift_dr@", m_state},{31'b0, shift_dr_o},         {31'b0, m_state == "SHIFT-DR"});
    chk({"pause_dr@", m_state},{31'b0, pause_dr_o},         {31'b0, m_state == "PAUSE-DR"});
    chk({"update_dr@", m_state},{31'b0, update_dr_o},       {31'b0, m_state == "UPD-DR"});
    chk({"capture_dr@", m_state},{31'b0, capture_dr_o},     {31'b0, m_state == "CAP-DR"});
    chk({"dbg_sel@", m_state}, {31'b0, debug_select_o},     {31'b0, m_ir == IR_DEBUG});
  endtask

  // One tck: inputs set while tck is low, outputs checked after the falling edge.
  task automatic step(input bit tms, input bit tdi, input bit dbg);
    tms_i       = tms;
    tdi_i       = tdi;
    debug_tdo_i = dbg;
    @(posedge tck_i);
    model_clock(tms, tdi);
    @(negedge tck_i);
    #2;
    check_outputs(dbg);
  endtask

  task automatic load_ir(input logic [3:0] op);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step((i == 3), op[i], 0);
    step(1, 0, 0);
    step(0, 0, 0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] word;
    logic [31:0] tdi_vec;
    logic [31:0] exp_word;
    logic [3:0]  nib;
    logic [3:0]  pat;
    bit          d;

    build_table();
    model_reset();
    trstn_i     = 1'b0;
    tms_i       = 1'b1;
    tdi_i       = 1'b0;
    debug_tdo_i = 1'b0;
    @(negedge tck_i);
    #2;
    check_outputs(1'b0);
    trstn_i = 1'b1;

    // Scenario 1: TLR -> Shift-DR, shift 32 bits out.
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    tdi_vec = $urandom;
    step(0, tdi_vec[0], 0);
    word    = '0;
    word[0] = tdo_o;
    for (int i = 1; i < 32; i++) begin
      step(0, tdi_vec[i], 0);
      word[i] = tdo_o;
      chk("s1_oe", {31'b0, tdo_oe_o}, 32'd1);
    end
    exp_word = IDCODE_EN ? IDCODE_VALUE : {tdi_vec[31:1], 1'b0};
    chk("s1_dr_word", word, exp_word);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Scenario 2: load BYPASS, check captured IR bits, then bypass delay.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    nib[0] = tdo_o;
    for (int i = 1; i < 4; i++) begin
      step(0, 1, 0);
      nib[i] = tdo_o;
    end
    chk("s2_ir_capture", {28'b0, nib}, 32'h1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("s2_dbg_sel", {31'b0, debug_select_o}, 32'd0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    nib[0] = tdo_o;
    pat = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      step(0, pat[i], 0);
      nib[i+1] = tdo_o;
    end
    chk("s2_bypass", {28'b0, nib}, 32'h6);
    step(1, pat[3], 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Scenario 3: DEBUG instruction and full DR strobe walk.
    load_ir(IR_DEBUG);
    chk("s3_dbg_sel", {31'b0, debug_select_o}, 32'd1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("s3_capture", {31'b0, capture_dr_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      d = 1'($urandom);
      step(0, 1'($urandom), d);
      chk("s3_tdo_mirror", {31'b0, tdo_o}, {31'b0, d});
    end
    step(1, 0, 0);
    step(0, 0, 0);
    chk("s3_pause", {31'b0, pause_dr_o}, 32'd1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("s3_update", {31'b0, update_dr_o}, 32'd1);
    step(0, 0, 0);

    // Scenario 4: five TMS=1 from Shift-IR with IR=DEBUG.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1'($urandom), 0);
    chk("s4_tlr", {31'b0, test_logic_reset_o}, 32'd1);
    chk("s4_dbg_sel", {31'b0, debug_select_o}, 32'd0);

    // Scenario 5: asynchronous reset in the middle of Shift-DR.
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    trstn_i = 1'b0;
    #1;
    model_reset();
    check_outputs(debug_tdo_i);
    chk("s5_oe_async", {31'b0, tdo_oe_o}, 32'd0);
    @(negedge tck_i);
    #2;
    trstn_i = 1'b1;

    // Random walk, with a forced return to TLR every 100 steps.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 5) < 2, 1'($urandom), 1'($urandom));
      if (n % 100 == 99) begin
        for (int i = 0; i < 5; i++) step(1, 1'($urandom), 1'($urandom));
        chk("rnd_tlr", {31'b0, test_logic_reset_o}, 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adbg_tap_ctrl.md
# adbg_tap_ctrl

IEEE 1149.1 TAP controller that drives the debug-register side of the advanced debug interface. It decodes TMS into the 16-state TAP FSM and holds the instruction register. It produces the shift/pause/update/capture strobes and the DEBUG instruction select consumed by the AXI debug top. It owns the chip-level TDO multiplexing between the IR, BYPASS, IDCODE and the debug module's serial output.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register length.
- IDCODE_VALUE, 32'h149511C3, value shifted out by IDCODE; bit 0 must be 1.
- IR_IDCODE, 4'b0010, IDCODE opcode.
- IR_DEBUG, 4'b1000, DEBUG opcode (selects the debug data register).
- IR_BYPASS, 4'b1111, BYPASS opcode.

Ports:
- tck_i  in  1  JTAG clock; the only clock; all logic on posedge except TDO (negedge).
- trstn_i  in  1  asynchronous active-low reset.
- tms_i  in  1  test mode select.
- tdi_i  in  1  serial data in; also fans out to the debug module unchanged.
- tdo_o  out  1  serial data out, negedge-registered.
- tdo_oe_o  out  1  TDO output enable, negedge-registered.
- debug_tdo_i  in  1  serial output of the debug module.
- debug_select_o  out  1  IR == IR_DEBUG.
- shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o  out  1 each  high while the FSM is in the corresponding DR state.
- test_logic_reset_o  out  1  high in Test-Logic-Reset.

## Operation
- FSM: the standard 16 states. TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the IR equivalents. Transitions follow 1149.1 on each posedge tck_i from tms_i.
  - TLR stays on TMS=1 and goes to RTI on 0.
  - Select-IR with TMS=1 goes to TLR.
  - Five consecutive TMS=1 reach TLR from any state.
- IR shift register, IR_WIDTH bits:
  - Capture-IR loads {0…,2'b01}.
  - Shift-IR shifts right, with tdi_i entering the MSB.
  - Update-IR copies it into the IR.
  - IR holds in all other states.
- TLR forces IR = IR_IDCODE (see Configuration).
- Unknown opcodes behave as BYPASS.
- BYPASS register, 1 bit: Capture-DR loads 0; Shift-DR loads tdi_i.
- IDCODE register, 32 bits: Capture-DR loads IDCODE_VALUE; Shift-DR shifts right, with tdi_i entering bit 31.
- The DEBUG data path is owned by the debug module. This block only supplies strobes and debug_select_o.
- TDO source (combinational, then registered on negedge):
  - Shift-IR: IR shift bit 0.
  - Shift-DR with DEBUG: debug_tdo_i.
  - Shift-DR with IDCODE: IDCODE bit 0.
  - Shift-DR with any other IR: bypass bit.
  - Otherwise: 0.
- tdo_oe_o = 1 only when the current state is Shift-IR or Shift-DR.

## Timing
- Reset values:
  - state = TLR.
  - IR = IR_IDCODE.
  - IR shift = 0, bypass = 0, IDCODE shift = IDCODE_VALUE.
  - tdo_o = 0, tdo_oe_o = 0.
  - test_logic_reset_o = 1; all DR strobes 0; debug_select_o = 0.
- Strobes are Moore decodes of the state register. They are valid for the entire tck period of that state, so the debug module samples them on the same posedge that leaves the state.
- Update-IR:
  - The IR changes on the posedge leaving Update-IR.
  - debug_select_o changes in the same cycle.
- Bypass adds exactly one tck of delay from TDI to TDO.
- The first Shift-DR TDO bit is valid after the falling edge following entry into Shift-DR.
- Async reset mid-shift aborts the shift immediately. The IR does not take the partial value.
- TMS-driven TLR during Shift-IR also discards the partial IR value.

## Configuration
- JTAG_IDCODE_EN defined:
  - IDCODE register present.
  - TLR and reset load IR_IDCODE.
- JTAG_IDCODE_EN undefined:
  - No IDCODE register.
  - IR_IDCODE decodes as BYPASS.
  - TLR and reset load IR_BYPASS.
  - Shift-DR after reset returns 0 then TDI delayed by one.

## Test plan
- Release trstn_i; TMS 0,1,0,0; shift 32 bits of TDI=0 -> tdo_o yields 32'h149511C3 LSB first, and tdo_oe_o is 1 throughout.
- Load IR 4'b1111 via Shift-IR with TDI=1; check captured IR bits out: 1,0,0,0. Then in Shift-DR drive TDI pattern 1011 -> tdo_o returns 0,1,1,0 (one-cycle delay).
- Load IR_DEBUG -> debug_select_o=1 after Update-IR. Walk Capture-DR/Shift-DR×3/Exit1/Pause/Exit2/Update:
  - Each strobe is high exactly in its state.
  - tdo_o mirrors debug_tdo_i one negedge later.
- During Shift-IR with IR=DEBUG, apply TMS=1 ×5 -> state TLR, test_logic_reset_o=1, IR=IDCODE, debug_select_o=0.
- Assert trstn_i low mid Shift-DR -> all outputs at reset values immediately, without waiting for tck.
- Build without JTAG_IDCODE_EN; repeat the first scenario -> tdo_o yields 0 then TDI delayed by one tck.
